// File: rtl/lcd_power_seq_if.sv
// Panel power-sequencer signal bundle: enable/frame inputs from the pixel
// pipeline, power/data/backlight controls and status back out.
interface lcd_power_seq_if;
  logic       en_sync;
  logic       frame_start;
  logic       panel_pwr_en;
  logic       lvds_data_en;
  logic       bl_en;
  logic       pwr_good;
  logic       busy;
  logic [2:0] state_o;

  modport master (
    output en_sync, frame_start,
    input  panel_pwr_en, lvds_data_en, bl_en, pwr_good, busy, state_o
  );

  modport slave (
    input  en_sync, frame_start,
    output panel_pwr_en, lvds_data_en, bl_en, pwr_good, busy, state_o
  );
endinterface

// File: rtl/lcd_power_seq.sv
// LVDS panel power sequencer: orders VDD, LVDS data and backlight with
// programmable dwell times, aligning data turn-on to a frame start.
module lcd_power_seq #(
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned T1_CYCLES = 742500,
  parameter int unsigned T2_CYCLES = 742500,
  parameter int unsigned T3_CYCLES = 742500,
  parameter int unsigned T4_CYCLES = 742500,
  parameter int unsigned T5_CYCLES = 7425000
) (
  input  logic              clk_sync,
  input  logic              rstn_sync,
  lcd_power_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_PWR_UP     = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_DATA_ON    = 3'd3,
    S_ACTIVE     = 3'd4,
    S_BL_OFF     = 3'd5,
    S_DATA_OFF   = 3'd6,
    S_COOL       = 3'd7
  } state_t;

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_WIDTH;
  localparam bit PARAMS_OK =
      (T1_CYCLES >= 1) && (longint'(T1_CYCLES) < CNT_SPAN) &&
      (T2_CYCLES >= 1) && (longint'(T2_CYCLES) < CNT_SPAN) &&
      (T3_CYCLES >= 1) && (longint'(T3_CYCLES) < CNT_SPAN) &&
      (T4_CYCLES >= 1) && (longint'(T4_CYCLES) < CNT_SPAN) &&
      (T5_CYCLES >= 1) && (longint'(T5_CYCLES) < CNT_SPAN);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("lcd_power_seq: every Tn must be >= 1 and fit in CNT_WIDTH bits");
    end
  endgenerate

  // Each timed state loads Tn-1 so that exit happens on the Tn-th edge.
  localparam logic [CNT_WIDTH-1:0] T1_LOAD = CNT_WIDTH'(T1_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] T2_LOAD = CNT_WIDTH'(T2_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] T3_LOAD = CNT_WIDTH'(T3_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] T4_LOAD = CNT_WIDTH'(T4_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] T5_LOAD = CNT_WIDTH'(T5_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                   timeout;

  assign timeout = (cnt == '0);

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = timeout ? '0 : cnt - 1'b1;
    case (state)
      S_OFF: begin
        if (bus.en_sync) begin
          state_nxt = S_PWR_UP;
          cnt_nxt   = T1_LOAD;
        end
      end
      S_PWR_UP: begin
        if (!bus.en_sync) begin
          state_nxt = S_DATA_OFF;
          cnt_nxt   = T4_LOAD;
        end else if (timeout) begin
          state_nxt = S_WAIT_FRAME;
        end
      end
      S_WAIT_FRAME: begin
        if (!bus.en_sync) begin
          state_nxt = S_DATA_OFF;
          cnt_nxt   = T4_LOAD;
        end else if (bus.frame_start) begin
          state_nxt = S_DATA_ON;
          cnt_nxt   = T2_LOAD;
        end
      end
      S_DATA_ON: begin
        if (!bus.en_sync) begin
          state_nxt = S_BL_OFF;
          cnt_nxt   = T3_LOAD;
        end else if (timeout) begin
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!bus.en_sync) begin
          state_nxt = S_BL_OFF;
          cnt_nxt   = T3_LOAD;
        end
      end
      // Power-down path ignores en_sync so the panel always completes it.
      S_BL_OFF: begin
        if (timeout) begin
          state_nxt = S_DATA_OFF;
          cnt_nxt   = T4_LOAD;
        end
      end
      S_DATA_OFF: begin
        if (timeout) begin
          state_nxt = S_COOL;
          cnt_nxt   = T5_LOAD;
        end
      end
      S_COOL: begin
        if (timeout) state_nxt = S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clk_sync or negedge rstn_sync) begin
    if (!rstn_sync) begin
      // NOTE: control outputs are reset with the state so the panel is dark with no clock.
      state            <= S_OFF;
      cnt              <= '0;
      bus.panel_pwr_en <= 1'b0;
      bus.lvds_data_en <= 1'b0;
      bus.bl_en        <= 1'b0;
      bus.pwr_good     <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      bus.panel_pwr_en <= state_nxt inside {S_PWR_UP, S_WAIT_FRAME, S_DATA_ON,
                                            S_ACTIVE, S_BL_OFF, S_DATA_OFF};
      bus.lvds_data_en <= state_nxt inside {S_DATA_ON, S_ACTIVE, S_BL_OFF};
      bus.bl_en        <= (state_nxt == S_ACTIVE);
      bus.pwr_good     <= (state_nxt == S_ACTIVE);
      bus.busy         <= !(state_nxt inside {S_OFF, S_ACTIVE});
    end
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Directed bench for lcd_power_seq: a dwell-time model checked every cycle,
// pinned by hand-computed expectations at the scenario milestones.
module tb_lcd_power_seq;

  localparam int T1 = 4;
  localparam int T2 = 3;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 5;

  logic clk_sync = 1'b0;
  logic rstn_sync;
  int   checks = 0;
  int   errors = 0;

  lcd_power_seq_if bus_if();

  lcd_power_seq #(
    .CNT_WIDTH (8),
    .T1_CYCLES (T1),
    .T2_CYCLES (T2),
    .T3_CYCLES (T3),
    .T4_CYCLES (T4),
    .T5_CYCLES (T5)
  ) dut (
    .clk_sync  (clk_sync),
    .rstn_sync (rstn_sync),
    .bus       (bus_if)
  );

  always #5 clk_sync = ~clk_sync;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Model: which phase the panel is in and how many edges it has spent there.
  int m_st  = 0;
  int m_age = 0;

  function automatic int dwell(input int st);
    case (st)
      1:       return T1;
      3:       return T2;
      5:       return T3;
      6:       return T4;
      7:       return T5;
      default: return 0;
    endcase
  endfunction

  function automatic int model_next(input int st, input int age, input logic en, input logic fs);
    bit done;
    done = (dwell(st) != 0) && (age + 1 == dwell(st));
    if (st >= 1 && st <= 4 && !en) return (st >= 3) ? 5 : 6;
    case (st)
      0:       return en   ? 1 : 0;
      1:       return done ? 2 : 1;
      2:       return fs   ? 3 : 2;
      3:       return done ? 4 : 3;
      4:       return 4;
      5:       return done ? 6 : 5;
      6:       return done ? 7 : 6;
      default: return done ? 0 : 7;
    endcase
  endfunction

  always @(posedge clk_sync or negedge rstn_sync) begin
    if (!rstn_sync) begin
      m_st  <= 0;
      m_age <= 0;
    end else begin
      m_st  <= model_next(m_st, m_age, bus_if.en_sync, bus_if.frame_start);
      m_age <= (model_next(m_st, m_age, bus_if.en_sync, bus_if.frame_start) != m_st) ? 0 : m_age + 1;
    end
  end

  always @(negedge clk_sync) begin
    check("cmp.state",        32'(bus_if.state_o),  32'(m_st));
    check("cmp.panel_pwr_en", 32'(bus_if.panel_pwr_en), 32'(m_st >= 1 && m_st <= 6));
    check("cmp.lvds_data_en", 32'(bus_if.lvds_data_en), 32'(m_st >= 3 && m_st <= 5));
    check("cmp.bl_en",        32'(bus_if.bl_en),    32'(m_st == 4));
    check("cmp.pwr_good",     32'(bus_if.pwr_good), 32'(m_st == 4));
    check("cmp.busy",         32'(bus_if.busy),     32'(m_st != 0 && m_st != 4));
    check("order", 32'((!bus_if.bl_en || bus_if.lvds_data_en) &&
                       (!bus_if.lvds_data_en || bus_if.panel_pwr_en)), 32'(1));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sync);
  endtask

  task automatic expect_outs(input string tag, input int st, input logic pwr,
                             input logic lvds, input logic bl, input logic busy);
    check({tag, ".state"},        32'(bus_if.state_o),      32'(st));
    check({tag, ".panel_pwr_en"}, 32'(bus_if.panel_pwr_en), 32'(pwr));
    check({tag, ".lvds_data_en"}, 32'(bus_if.lvds_data_en), 32'(lvds));
    check({tag, ".bl_en"},        32'(bus_if.bl_en),        32'(bl));
    check({tag, ".pwr_good"},     32'(bus_if.pwr_good),     32'(bl));
    check({tag, ".busy"},         32'(bus_if.busy),         32'(busy));
  endtask

  // Entered at a negedge; E0 is the next rising edge.
  task automatic power_up(input string tag);
    rstn_sync = 1'b1;
    bus_if.en_sync = 1'b1;
    bus_if.frame_start = 1'b0;
    cyc(1); expect_outs({tag, ".E0"},  1, 1, 0, 0, 1);
    cyc(4); expect_outs({tag, ".E4"},  2, 1, 0, 0, 1);
    cyc(5);
    bus_if.frame_start = 1'b1;
    cyc(1);
    bus_if.frame_start = 1'b0;
    expect_outs({tag, ".E10"}, 3, 1, 1, 0, 1);
    cyc(2); expect_outs({tag, ".E12"}, 3, 1, 1, 0, 1);
    cyc(1); expect_outs({tag, ".E13"}, 4, 1, 1, 1, 0);
  endtask

  task automatic power_down(input string tag);
    bus_if.en_sync = 1'b0;
    cyc(1); expect_outs({tag, ".F0"},  5, 1, 1, 0, 1);
    cyc(1); expect_outs({tag, ".F1"},  5, 1, 1, 0, 1);
    cyc(1); expect_outs({tag, ".F2"},  6, 1, 0, 0, 1);
    cyc(3); expect_outs({tag, ".F5"},  7, 0, 0, 0, 1);
    cyc(4); expect_outs({tag, ".F9"},  7, 0, 0, 0, 1);
    cyc(1); expect_outs({tag, ".F10"}, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rstn_sync = 1'b1;
    bus_if.en_sync = 1'b0;
    bus_if.frame_start = 1'b0;
    #1 rstn_sync = 1'b0;
    #1 expect_outs("reset0", 0, 0, 0, 0, 0);
    cyc(2);

    power_up("s1");
    cyc(3);
    power_down("s2");

    // Abort in WAIT_FRAME with a coincident frame_start.
    cyc(2);
    bus_if.en_sync = 1'b1;
    cyc(1); expect_outs("s4.G0", 1, 1, 0, 0, 1);
    cyc(4); expect_outs("s4.G4", 2, 1, 0, 0, 1);
    cyc(2); expect_outs("s4.G6", 2, 1, 0, 0, 1);
    bus_if.en_sync = 1'b0;
    bus_if.frame_start = 1'b1;
    cyc(1);
    bus_if.frame_start = 1'b0;
    expect_outs("s4.H0", 6, 1, 0, 0, 1);
    cyc(2); expect_outs("s4.H2", 6, 1, 0, 0, 1);
    cyc(1); expect_outs("s4.H3", 7, 0, 0, 0, 1);
    cyc(5); expect_outs("s4.H8", 0, 0, 0, 0, 0);

    // Abort during PWR_UP, then re-enable while cooling.
    cyc(1);
    bus_if.en_sync = 1'b1;
    cyc(1); expect_outs("s5.J0", 1, 1, 0, 0, 1);
    bus_if.en_sync = 1'b0;
    cyc(1); expect_outs("s5.J1", 6, 1, 0, 0, 1);
    cyc(3); expect_outs("s5.J4", 7, 0, 0, 0, 1);
    bus_if.en_sync = 1'b1;
    cyc(4); expect_outs("s5.J8",  7, 0, 0, 0, 1);
    cyc(1); expect_outs("s5.J9",  0, 0, 0, 0, 0);
    cyc(1); expect_outs("s5.J10", 1, 1, 0, 0, 1);

    // Frame pulses during PWR_UP and on its timeout edge are dropped.
    cyc(1);
    bus_if.frame_start = 1'b1;
    cyc(1);
    bus_if.frame_start = 1'b0;
    expect_outs("s3.E2", 1, 1, 0, 0, 1);
    cyc(1);
    bus_if.frame_start = 1'b1;
    cyc(1);
    bus_if.frame_start = 1'b0;
    expect_outs("s3.E4", 2, 1, 0, 0, 1);
    cyc(2); expect_outs("s3.hold", 2, 1, 0, 0, 1);
    bus_if.frame_start = 1'b1;
    cyc(1);
    bus_if.frame_start = 1'b0;
    expect_outs("s3.frame", 3, 1, 1, 0, 1);
    cyc(3); expect_outs("s3.active", 4, 1, 1, 1, 0);

    // Asynchronous reset between edges while ACTIVE.
    cyc(2);
    @(posedge clk_sync);
    #2 rstn_sync = 1'b0;
    #1 expect_outs("s6.async", 0, 0, 0, 0, 0);
    @(negedge clk_sync);
    power_up("s6");
    power_down("s6.down");

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
